mem_pix_stage: RTL

Memory stage of the PDA pipeline, between the EX/MEM and MEM/WB registers. Consumes the execute-stage payload and control (ALU result, trig result, pixel coordinates Ax/Ay, write data WD, destination Rd), performs data-memory and pixel-memory accesses, and registers the MEM/WB payload and control. Data memory is single-cycle. Pixel memory uses a variable-latency req/ack handshake with a timeout, and the stage stalls the front of the pipeline while a pixel access is outstanding.

---
 rtl/mem_pix_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_pix_stage.sv
// Memory stage between EX/MEM and MEM/WB: single-cycle data memory plus a
// req/ack pixel memory with timeout that stalls the front of the pipeline.
module mem_pix_stage #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int PIX_AW      = 19,
  parameter int DMEM_AW     = 10,
  parameter int PIX_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_i,
  input  logic [5:0]         cu_i,
  input  logic [163:0]       data_i,
  output logic               stall_o,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  output logic               pix_req,
  output logic               pix_we,
  output logic [PIX_AW-1:0]  pix_addr,
  output logic [7:0]         pix_wdata,
  input  logic               pix_ack,
  input  logic [7:0]         pix_rdata,
  output logic               valid_o,
  output logic [3:0]         cu_o,
  output logic [163:0]       data_o,
  output logic               pix_err_o,
  output logic               pix_oob_o,
  output logic               dbg_state
);

  // Handshake: pix_req stays high for the whole WAIT state with address,
  // data and we held stable; a cycle with pix_req && pix_ack completes the
  // access. pix_ack outside WAIT is ignored.

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam int CNT_W = $clog2(PIX_TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;

  logic [3:0]         rd;
  logic signed [31:0] alu_res;
  logic signed [31:0] trig_res;
  logic signed [31:0] ax;
  logic signed [31:0] ay;
  logic [31:0]        wd;

  logic               pc_src;
  logic               reg_write;
  logic               mem_write;
  logic               mem_pix_write;
  logic [1:0]         mem_to_reg;

  logic               pix_op;
  logic               in_range;
  logic               pix_go;
  logic               timeout;
  logic signed [31:0] pix_lin;
  logic [3:0]         cu_next;
  logic [31:0]        pix_rd_val;

  assign rd       = data_i[163:160];
  assign alu_res  = data_i[159:128];
  assign trig_res = data_i[127:96];
  assign ax       = data_i[95:64];
  assign ay       = data_i[63:32];
  assign wd       = data_i[31:0];

  assign {pc_src, reg_write, mem_write, mem_pix_write, mem_to_reg} = cu_i;

  assign pix_op   = valid_i && (mem_pix_write || (mem_to_reg == 2'b10));
  assign in_range = (ax >= 0) && (ax < IMG_W) && (ay >= 0) && (ay < IMG_H);
  assign pix_go   = (state == S_IDLE) && pix_op && in_range;
  assign timeout  = (state == S_WAIT) && !pix_ack &&
                    (wait_cnt == CNT_W'(PIX_TIMEOUT - 1));
  assign stall_o  = pix_go || ((state == S_WAIT) && !pix_ack && !timeout);
  assign pix_lin  = ay * IMG_W + ax;

  assign dmem_addr  = alu_res[DMEM_AW+1:2];
  assign dmem_we    = valid_i && mem_write && !stall_o;
  assign dmem_wdata = wd;

  assign pix_req   = (state == S_WAIT);
  assign dbg_state = state;

  assign cu_next    = valid_i ? {reg_write, pc_src, mem_to_reg} : 4'b0;
  // Read data only counts on a real ack of a read; timeouts and writes give 0.
  assign pix_rd_val = ((state == S_WAIT) && pix_ack && !pix_we) ?
                      {24'b0, pix_rdata} : 32'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      pix_addr  <= '0;
      pix_we    <= 1'b0;
      pix_wdata <= 8'b0;
      valid_o   <= 1'b0;
      cu_o      <= 4'b0;
      data_o    <= '0;
      pix_err_o <= 1'b0;
      pix_oob_o <= 1'b0;
    end else begin
      if (stall_o) begin
        valid_o <= 1'b0;
        cu_o    <= 4'b0;
      end else begin
        valid_o <= valid_i;
        cu_o    <= cu_next;
        data_o  <= {32'b0, dmem_rdata, pix_rd_val, alu_res, trig_res, rd};
      end

      case (state)
        S_IDLE: begin
          if (pix_go) begin
            state     <= S_WAIT;
            wait_cnt  <= '0;
            pix_addr  <= pix_lin[PIX_AW-1:0];
            pix_we    <= mem_pix_write;
            pix_wdata <= wd[7:0];
          end else if (pix_op) begin
            pix_oob_o <= 1'b1;
          end
        end
        S_WAIT: begin
          if (pix_ack || timeout) begin
            state  <= S_IDLE;
            pix_we <= 1'b0;
            if (timeout) pix_err_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
